axi4_lite_reg_slice: RTL and testbench



---
 rtl/axi4_lite_reg_slice_if.sv | 41 ++++
 rtl/axi4_lite_reg_slice.sv | 189 ++++++++++++++++++
 tb/tb_axi4_lite_reg_slice.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_reg_slice_if.sv
// AXI4-Lite link bundle: one set of AW/W/B/AR/R wires with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
) ();
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport mst_port (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slv_port (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/axi4_lite_reg_slice.sv
// Full AXI4-Lite register slice: a 2-entry skid buffer per channel, all ready/valid from flops.
// Optional transaction counters are built when AXI4_LITE_REG_SLICE_TXN_CNT_EN is defined.
module axi4_lite_reg_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         src_valid_i,
  output logic         src_ready_o,
  input  logic [W-1:0] src_data_i,
  output logic         snk_valid_o,
  input  logic         snk_ready_i,
  output logic [W-1:0] snk_data_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e         state_q, state_d;
  logic           src_rdy_q, src_rdy_d;
  logic           snk_vld_q, snk_vld_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           src_hs, snk_hs;

  assign src_hs = src_valid_i & src_rdy_q;
  assign snk_hs = snk_vld_q & snk_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      src_rdy_q <= 1'b0;
      snk_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_rdy_q <= src_rdy_d;
      snk_vld_q <= snk_vld_d;
    end
  end

  // Payload storage is deliberately unreset; the valid flops qualify it.
  always_ff @(posedge clk_i) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (src_hs) state_d = ONE;
      ONE: begin
        if (src_hs && !snk_hs)      state_d = FULL;
        else if (!src_hs && snk_hs) state_d = EMPTY;
      end
      FULL:    if (snk_hs) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // main_q always holds the oldest entry; skid_q only the second one while FULL.
  always_comb begin
    main_d    = main_q;
    skid_d    = skid_q;
    src_rdy_d = (state_d != FULL);
    snk_vld_d = (state_d != EMPTY);
    case (state_q)
      EMPTY: if (src_hs) main_d = src_data_i;
      ONE: begin
        if (src_hs && snk_hs) main_d = src_data_i;
        else if (src_hs)      skid_d = src_data_i;
      end
      FULL:    if (snk_hs) main_d = skid_q;
      default: ;
    endcase
  end

  assign src_ready_o = src_rdy_q;
  assign snk_valid_o = snk_vld_q;
  assign snk_data_o  = main_q;
endmodule

module axi4_lite_reg_slice #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic          i_clk,
  input  logic          i_async_rst,
  axi4_lite_if.slv_port if_s_axi4_lite,
  axi4_lite_if.mst_port if_m_axi4_lite,
  output logic [15:0]   o_wr_txn_cnt,
  output logic [15:0]   o_rd_txn_cnt
);
  localparam int STRB_W = DATA_BIT_WIDTH / 8;
  localparam int AX_W   = ADDR_BIT_WIDTH + 3;
  localparam int W_W    = DATA_BIT_WIDTH + STRB_W;
  localparam int B_W    = 2;
  localparam int R_W    = DATA_BIT_WIDTH + 2;

  logic [AX_W-1:0] aw_src, aw_snk, ar_src, ar_snk;
  logic [W_W-1:0]  w_src, w_snk;
  logic [B_W-1:0]  b_src, b_snk;
  logic [R_W-1:0]  r_src, r_snk;
  logic aw_src_rdy, aw_snk_vld, w_src_rdy, w_snk_vld, ar_src_rdy, ar_snk_vld;
  logic b_src_rdy, b_snk_vld, r_src_rdy, r_snk_vld;

  assign aw_src = {if_s_axi4_lite.awaddr, if_s_axi4_lite.awprot};
  assign w_src  = {if_s_axi4_lite.wdata, if_s_axi4_lite.wstrb};
  assign ar_src = {if_s_axi4_lite.araddr, if_s_axi4_lite.arprot};
  assign b_src  = if_m_axi4_lite.bresp;
  assign r_src  = {if_m_axi4_lite.rdata, if_m_axi4_lite.rresp};

  axi4_lite_reg_slice_skid #(.W(AX_W)) u_aw (
    .clk_i(i_clk), .rst_i(i_async_rst),
    .src_valid_i(if_s_axi4_lite.awvalid), .src_ready_o(aw_src_rdy), .src_data_i(aw_src),
    .snk_valid_o(aw_snk_vld), .snk_ready_i(if_m_axi4_lite.awready), .snk_data_o(aw_snk)
  );

  axi4_lite_reg_slice_skid #(.W(W_W)) u_w (
    .clk_i(i_clk), .rst_i(i_async_rst),
    .src_valid_i(if_s_axi4_lite.wvalid), .src_ready_o(w_src_rdy), .src_data_i(w_src),
    .snk_valid_o(w_snk_vld), .snk_ready_i(if_m_axi4_lite.wready), .snk_data_o(w_snk)
  );

  axi4_lite_reg_slice_skid #(.W(AX_W)) u_ar (
    .clk_i(i_clk), .rst_i(i_async_rst),
    .src_valid_i(if_s_axi4_lite.arvalid), .src_ready_o(ar_src_rdy), .src_data_i(ar_src),
    .snk_valid_o(ar_snk_vld), .snk_ready_i(if_m_axi4_lite.arready), .snk_data_o(ar_snk)
  );

  // Response channels flow from the m-port back to the s-port.
  axi4_lite_reg_slice_skid #(.W(B_W)) u_b (
    .clk_i(i_clk), .rst_i(i_async_rst),
    .src_valid_i(if_m_axi4_lite.bvalid), .src_ready_o(b_src_rdy), .src_data_i(b_src),
    .snk_valid_o(b_snk_vld), .snk_ready_i(if_s_axi4_lite.bready), .snk_data_o(b_snk)
  );

  axi4_lite_reg_slice_skid #(.W(R_W)) u_r (
    .clk_i(i_clk), .rst_i(i_async_rst),
    .src_valid_i(if_m_axi4_lite.rvalid), .src_ready_o(r_src_rdy), .src_data_i(r_src),
    .snk_valid_o(r_snk_vld), .snk_ready_i(if_s_axi4_lite.rready), .snk_data_o(r_snk)
  );

  assign if_s_axi4_lite.awready = aw_src_rdy;
  assign if_s_axi4_lite.wready  = w_src_rdy;
  assign if_s_axi4_lite.arready = ar_src_rdy;
  assign if_s_axi4_lite.bvalid  = b_snk_vld;
  assign if_s_axi4_lite.bresp   = b_snk;
  assign if_s_axi4_lite.rvalid  = r_snk_vld;
  assign if_s_axi4_lite.rdata   = r_snk[R_W-1:2];
  assign if_s_axi4_lite.rresp   = r_snk[1:0];

  assign if_m_axi4_lite.awvalid = aw_snk_vld;
  assign if_m_axi4_lite.awaddr  = aw_snk[AX_W-1:3];
  assign if_m_axi4_lite.awprot  = aw_snk[2:0];
  assign if_m_axi4_lite.wvalid  = w_snk_vld;
  assign if_m_axi4_lite.wdata   = w_snk[W_W-1:STRB_W];
  assign if_m_axi4_lite.wstrb   = w_snk[STRB_W-1:0];
  assign if_m_axi4_lite.arvalid = ar_snk_vld;
  assign if_m_axi4_lite.araddr  = ar_snk[AX_W-1:3];
  assign if_m_axi4_lite.arprot  = ar_snk[2:0];
  assign if_m_axi4_lite.bready  = b_src_rdy;
  assign if_m_axi4_lite.rready  = r_src_rdy;

`ifdef AXI4_LITE_REG_SLICE_TXN_CNT_EN
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  // Counted on the s-side response handshakes, i.e. transactions seen complete upstream.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (b_snk_vld && if_s_axi4_lite.bready) wr_cnt_d = wr_cnt_q + 16'd1;
    if (r_snk_vld && if_s_axi4_lite.rready) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      wr_cnt_q <= 16'd0;
      rd_cnt_q <= 16'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign o_wr_txn_cnt = wr_cnt_q;
  assign o_rd_txn_cnt = rd_cnt_q;
`else
  assign o_wr_txn_cnt = 16'd0;
  assign o_rd_txn_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_axi4_lite_reg_slice.sv
// Scenario bench for axi4_lite_reg_slice: scoreboard queues filled at source handshakes, drained at sink handshakes.
module tb_axi4_lite_reg_slice;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXI4_LITE_REG_SLICE_TXN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wr_cnt, rd_cnt;
  int          checks = 0;
  int          failures = 0;

  logic [AW+2:0] awq[$];
  logic [DW+3:0] wq[$];
  logic [1:0]    bq[$];
  logic [AW+2:0] arq[$];
  logic [DW+1:0] rq[$];

  axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) s_if ();
  axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) m_if ();

  axi4_lite_reg_slice #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) dut (
    .i_clk(clk), .i_async_rst(rst),
    .if_s_axi4_lite(s_if), .if_m_axi4_lite(m_if),
    .o_wr_txn_cnt(wr_cnt), .o_rd_txn_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_if.awvalid = 0; s_if.awaddr = '0; s_if.awprot = '0;
    s_if.wvalid = 0;  s_if.wdata = '0;  s_if.wstrb = '0;
    s_if.arvalid = 0; s_if.araddr = '0; s_if.arprot = '0;
    s_if.bready = 1;  s_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    m_if.bvalid = 0;  m_if.bresp = '0;
    m_if.rvalid = 0;  m_if.rdata = '0; m_if.rresp = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (2) step();
    @(negedge clk);
    checks++;
    if ({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=00000", {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready});
    end
    checks++;
    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=00000", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid});
    end
    checks++;
    if ({wr_cnt, rd_cnt} !== 32'h0) begin
      failures++; $display("FAIL reset_cnt got=%h exp=0", {wr_cnt, rd_cnt});
    end
    step();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} !== 5'b0) begin
      failures++;
      $display("FAIL rel_ready_pre got=%b exp=00000", {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready});
    end
    step();
    @(negedge clk);
    checks++;
    if ({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} !== 5'b11111) begin
      failures++;
      $display("FAIL rel_ready_post got=%b exp=11111", {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready});
    end
  endtask

  task automatic test_pass_through();
    logic [AW+2:0] eaw;
    logic [DW+3:0] ew;
    logic [1:0]    eb;
    step();
    s_if.awvalid = 1; s_if.awaddr = 32'h0000_0004; s_if.awprot = 3'b000;
    s_if.wvalid = 1;  s_if.wdata = 32'hDEAD_BEEF;  s_if.wstrb = 4'hF;
    @(negedge clk);
    checks++;
    if ({s_if.awready, s_if.wready} !== 2'b11) begin
      failures++; $display("FAIL pt_src_ready got=%b exp=11", {s_if.awready, s_if.wready});
    end
    if (s_if.awready) awq.push_back({32'h0000_0004, 3'b000});
    if (s_if.wready)  wq.push_back({32'hDEAD_BEEF, 4'hF});
    checks++;
    if ({m_if.awvalid, m_if.wvalid} !== 2'b00) begin
      failures++; $display("FAIL pt_early_valid got=%b exp=00", {m_if.awvalid, m_if.wvalid});
    end
    step();
    s_if.awvalid = 0; s_if.awaddr = '1; s_if.wvalid = 0; s_if.wdata = '0; s_if.wstrb = '0;
    @(negedge clk);
    checks++;
    if ({m_if.awvalid, m_if.wvalid} !== 2'b11) begin
      failures++; $display("FAIL pt_latency got=%b exp=11", {m_if.awvalid, m_if.wvalid});
    end
    if (m_if.awvalid && awq.size() > 0) begin
      eaw = awq.pop_front();
      checks++;
      if ({m_if.awaddr, m_if.awprot} !== eaw) begin
        failures++; $display("FAIL pt_aw_payload got=%h exp=%h", {m_if.awaddr, m_if.awprot}, eaw);
      end
    end
    if (m_if.wvalid && wq.size() > 0) begin
      ew = wq.pop_front();
      checks++;
      if ({m_if.wdata, m_if.wstrb} !== ew) begin
        failures++; $display("FAIL pt_w_payload got=%h exp=%h", {m_if.wdata, m_if.wstrb}, ew);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if ({m_if.awvalid, m_if.wvalid} !== 2'b00) begin
      failures++; $display("FAIL pt_dup_valid got=%b exp=00", {m_if.awvalid, m_if.wvalid});
    end
    step();
    m_if.bvalid = 1; m_if.bresp = 2'b00;
    @(negedge clk);
    checks++;
    if (m_if.bready !== 1'b1) begin
      failures++; $display("FAIL pt_bready got=%b exp=1", m_if.bready);
    end
    if (m_if.bready) bq.push_back(2'b00);
    checks++;
    if (s_if.bvalid !== 1'b0) begin
      failures++; $display("FAIL pt_b_early got=%b exp=0", s_if.bvalid);
    end
    step();
    m_if.bvalid = 0; m_if.bresp = 2'b11;
    @(negedge clk);
    checks++;
    if (s_if.bvalid !== 1'b1) begin
      failures++; $display("FAIL pt_b_latency got=%b exp=1", s_if.bvalid);
    end
    if (s_if.bvalid && bq.size() > 0) begin
      eb = bq.pop_front();
      checks++;
      if (s_if.bresp !== eb) begin
        failures++; $display("FAIL pt_bresp got=%b exp=%b", s_if.bresp, eb);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (s_if.bvalid !== 1'b0 || awq.size() != 0 || wq.size() != 0 || bq.size() != 0) begin
      failures++;
      $display("FAIL pt_drain got bvalid=%b q=%0d/%0d/%0d exp bvalid=0 q=0/0/0", s_if.bvalid, awq.size(), wq.size(), bq.size());
    end
  endtask

  task automatic test_back_pressure();
    logic [AW-1:0] addrs[3];
    bit            exp_rdy[8];
    bit            exp_mvld[8];
    logic [AW+2:0] e;
    int idx, nm, last;
    addrs    = '{32'h0, 32'h4, 32'h8};
    exp_rdy  = '{1, 1, 0, 0, 0, 1, 1, 1};
    exp_mvld = '{0, 1, 1, 1, 1, 1, 1, 0};
    idx = 0; nm = 0; last = 0;
    step();
    for (int c = 0; c < 8; c++) begin
      s_if.arvalid = (idx < 3);
      s_if.araddr  = (idx < 3) ? addrs[idx] : '0;
      s_if.arprot  = 3'(idx);
      m_if.arready = (c >= 4);
      @(negedge clk);
      checks++;
      if (s_if.arready !== exp_rdy[c]) begin
        failures++; $display("FAIL bp_arready c=%0d got=%b exp=%b", c, s_if.arready, exp_rdy[c]);
      end
      checks++;
      if (m_if.arvalid !== exp_mvld[c]) begin
        failures++; $display("FAIL bp_arvalid c=%0d got=%b exp=%b", c, m_if.arvalid, exp_mvld[c]);
      end
      if (m_if.arvalid && m_if.arready) begin
        checks++;
        if (arq.size() == 0) begin
          failures++; $display("FAIL bp_extra_ar got=%h exp=none", m_if.araddr);
        end else begin
          e = arq.pop_front();
          if ({m_if.araddr, m_if.arprot} !== e) begin
            failures++; $display("FAIL bp_order got=%h exp=%h", {m_if.araddr, m_if.arprot}, e);
          end
        end
        if (nm > 0) begin
          checks++;
          if (c != last + 1) begin
            failures++; $display("FAIL bp_gap got=%0d exp=%0d", c, last + 1);
          end
        end
        last = c; nm++;
      end
      if (s_if.arvalid && s_if.arready) begin
        arq.push_back({addrs[idx], 3'(idx)});
        idx++;
      end
      step();
    end
    s_if.arvalid = 0; m_if.arready = 1;
    checks++;
    if (nm != 3 || idx != 3) begin
      failures++; $display("FAIL bp_count got=%0d/%0d exp=3/3", nm, idx);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] data[100];
    logic [1:0]    resp[100];
    logic [DW+1:0] e;
    int sent, got, cyc, pc;
    bit ph2;
    for (int i = 0; i < 100; i++) begin
      data[i] = $urandom;
      resp[i] = 2'($urandom_range(0, 3));
    end
    sent = 0; got = 0; cyc = 0; pc = 0;
    step();
    while (got < 100 && cyc < 3000) begin
      ph2 = (sent >= 50);
      m_if.rvalid = (sent < 100) && (ph2 || $urandom_range(0, 1) == 1);
      m_if.rdata  = (sent < 100) ? data[sent] : '0;
      m_if.rresp  = (sent < 100) ? resp[sent] : '0;
      s_if.rready = ph2 || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (ph2 && pc >= 1) begin
        checks++;
        if (m_if.rready !== 1'b1) begin
          failures++; $display("FAIL st_src_rate pc=%0d got=%b exp=1", pc, m_if.rready);
        end
        if (rq.size() > 0) begin
          checks++;
          if (s_if.rvalid !== 1'b1) begin
            failures++; $display("FAIL st_snk_rate pc=%0d got=%b exp=1", pc, s_if.rvalid);
          end
        end
      end
      if (s_if.rvalid && s_if.rready) begin
        checks++;
        if (rq.size() == 0) begin
          failures++; $display("FAIL st_extra_r got=%h exp=none", s_if.rdata);
        end else begin
          e = rq.pop_front();
          if ({s_if.rdata, s_if.rresp} !== e) begin
            failures++; $display("FAIL st_rdata n=%0d got=%h exp=%h", got, {s_if.rdata, s_if.rresp}, e);
          end
        end
        got++;
      end
      if (m_if.rvalid && m_if.rready) begin
        rq.push_back({data[sent], resp[sent]});
        sent++;
      end
      if (ph2) pc++;
      step();
      cyc++;
    end
    m_if.rvalid = 0; s_if.rready = 1;
    checks++;
    if (got != 100 || rq.size() != 0) begin
      failures++; $display("FAIL st_timeout got=%0d pending=%0d exp=100/0", got, rq.size());
    end
    @(negedge clk);
    checks++;
    if (rd_cnt !== (CNT_EN ? 16'd100 : 16'd0)) begin
      failures++; $display("FAIL st_rd_cnt got=%0d exp=%0d", rd_cnt, CNT_EN ? 100 : 0);
    end
  endtask

  task automatic test_reset_midflight();
    step();
    m_if.awready = 0;
    s_if.awvalid = 1; s_if.awaddr = 32'h100; s_if.awprot = 3'd1;
    @(negedge clk);
    step();
    s_if.awaddr = 32'h104; s_if.awprot = 3'd2;
    @(negedge clk);
    step();
    s_if.awvalid = 0;
    @(negedge clk);
    checks++;
    if ({m_if.awvalid, s_if.awready} !== 2'b10) begin
      failures++; $display("FAIL rm_full got=%b exp=10", {m_if.awvalid, s_if.awready});
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({m_if.awvalid, s_if.awready} !== 2'b00) begin
      failures++; $display("FAIL rm_async got=%b exp=00", {m_if.awvalid, s_if.awready});
    end
    checks++;
    if (rd_cnt !== 16'd0) begin
      failures++; $display("FAIL rm_cnt_clr got=%0d exp=0", rd_cnt);
    end
    step(); step();
    rst = 0; m_if.awready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (m_if.awvalid !== 1'b0) begin
        failures++; $display("FAIL rm_stale c=%0d got=%b exp=0", c, m_if.awvalid);
      end
      step();
    end
    s_if.awvalid = 1; s_if.awaddr = 32'h200; s_if.awprot = 3'd5;
    @(negedge clk);
    if (s_if.awready) awq.push_back({32'h200, 3'd5});
    checks++;
    if (s_if.awready !== 1'b1) begin
      failures++; $display("FAIL rm_new_ready got=%b exp=1", s_if.awready);
    end
    step();
    s_if.awvalid = 0;
    @(negedge clk);
    checks++;
    if (m_if.awvalid !== 1'b1 || awq.size() == 0) begin
      failures++; $display("FAIL rm_new_valid got=%b exp=1", m_if.awvalid);
    end else if ({m_if.awaddr, m_if.awprot} !== awq.pop_front()) begin
      failures++; $display("FAIL rm_new_payload got=%h exp=%h", {m_if.awaddr, m_if.awprot}, {32'h200, 3'd5});
    end
    step();
    @(negedge clk);
    checks++;
    if (m_if.awvalid !== 1'b0) begin
      failures++; $display("FAIL rm_after got=%b exp=0", m_if.awvalid);
    end
  endtask

  task automatic test_counter();
    logic [15:0] exp_wr;
    bit mh, sh, done;
    exp_wr = 16'd0;
    step();
`ifdef AXI4_LITE_REG_SLICE_TXN_CNT_EN
    begin
      int mn, sn, cyc;
      mn = 0; sn = 0; cyc = 0;
      m_if.bresp = 2'b00; s_if.bready = 1;
      while (sn < 65534 && cyc < 70000) begin
        m_if.bvalid = (mn < 65534);
        @(negedge clk);
        if (s_if.bvalid && s_if.bready) sn++;
        if (m_if.bvalid && m_if.bready) mn++;
        step();
        cyc++;
      end
      m_if.bvalid = 0;
      exp_wr = 16'(sn);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      m_if.bvalid = 1; m_if.bresp = 2'b00; s_if.bready = 1;
      done = 0;
      for (int c = 0; c < 8 && !done; c++) begin
        @(negedge clk);
        mh = m_if.bvalid && m_if.bready;
        sh = s_if.bvalid && s_if.bready;
        if (sh) begin
          checks++;
          if (wr_cnt !== (CNT_EN ? exp_wr : 16'd0)) begin
            failures++; $display("FAIL cnt_pre k=%0d got=%0d exp=%0d", k, wr_cnt, CNT_EN ? exp_wr : 16'd0);
          end
          exp_wr = exp_wr + 16'd1;
        end
        step();
        if (mh) m_if.bvalid = 0;
        if (sh) begin
          @(negedge clk);
          checks++;
          if (wr_cnt !== (CNT_EN ? exp_wr : 16'd0)) begin
            failures++; $display("FAIL cnt_post k=%0d got=%0d exp=%0d", k, wr_cnt, CNT_EN ? exp_wr : 16'd0);
          end
          done = 1;
          step();
        end
      end
      checks++;
      if (!done) begin
        failures++; $display("FAIL cnt_timeout k=%0d got=no_b exp=b_handshake", k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_back_pressure();
    test_streaming();
    test_reset_midflight();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
